// File: rtl/decode_pipe_if.sv
// Fetch-side and execute-side handshake bundle for decode_pipe.
interface decode_pipe_if #(
    parameter int unsigned PC_WIDTH = 32
) ();
    logic                in_valid;
    logic                in_ready;
    logic [PC_WIDTH-1:0] in_pc;
    logic [31:0]         in_instr;

    logic                out_valid;
    logic                out_ready;
    logic [PC_WIDTH-1:0] out_pc;
    logic [31:0]         out_instr;
    logic                out_reg_write;
    logic [4:0]          out_wsel;
    logic [1:0]          out_alu_op;
    logic                out_alu_src;
    logic                out_mem_read;
    logic                out_mem_write;
    logic                out_mem_sign;
    logic [1:0]          out_mem_width;
    logic                out_exc;
    logic [4:0]          out_exc_code;
    logic                out_eret;

    // Environment view: drives fetch side, consumes decoded entries.
    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_reg_write, out_wsel,
               out_alu_op, out_alu_src, out_mem_read, out_mem_write, out_mem_sign,
               out_mem_width, out_exc, out_exc_code, out_eret
    );

    // Decoder view.
    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_reg_write, out_wsel,
               out_alu_op, out_alu_src, out_mem_read, out_mem_write, out_mem_sign,
               out_mem_width, out_exc, out_exc_code, out_eret
    );
endinterface

// File: rtl/decode_pipe.sv
// Registered Minisys-1A decoder with a decoded-entry FIFO between fetch and execute.
// Optional load-use interlock enabled by defining DECODE_LOADUSE_INTERLOCK_EN.
module decode_pipe #(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    decode_pipe_if.slave           bus,
    output logic [STALL_CNT_W-1:0] stall_count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [31:0]         instr;
        logic                reg_write;
        logic [4:0]          wsel;
        logic [1:0]          alu_op;
        logic                alu_src;
        logic                mem_read;
        logic                mem_write;
        logic                mem_sign;
        logic [1:0]          mem_width;
        logic                exc;
        logic [4:0]          exc_code;
        logic                eret;
    } entry_t;

    logic [5:0] w_op;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    logic [5:0] w_funct;
    logic       w_rfmt;
    logic       w_ialu;
    logic       w_load;
    logic       w_store;
    logic       w_branch;
    logic       w_legal;
    entry_t     w_dec;

    assign w_op    = bus.in_instr[31:26];
    assign w_rs    = bus.in_instr[25:21];
    assign w_rt    = bus.in_instr[20:16];
    assign w_rd    = bus.in_instr[15:11];
    assign w_funct = bus.in_instr[5:0];
    assign w_rfmt  = (w_op == 6'h00);
    assign w_ialu  = (w_op[5:3] == 3'b001);
    assign w_load  = (w_op == 6'h20) || (w_op == 6'h21) || (w_op == 6'h23) ||
                     (w_op == 6'h24) || (w_op == 6'h25);
    assign w_store = (w_op == 6'h28) || (w_op == 6'h29) || (w_op == 6'h2B);

    // Combinational decode of the offered instruction into a FIFO entry.
    always_comb begin
        w_dec       = '0;
        w_legal     = 1'b0;
        w_branch    = 1'b0;
        w_dec.pc    = bus.in_pc;
        w_dec.instr = bus.in_instr;
        case (w_op)
            6'h00: begin
                case (w_funct)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h09, 6'h10, 6'h12,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B: begin
                        w_legal         = 1'b1;
                        w_dec.reg_write = 1'b1;
                        w_dec.wsel      = w_rd;
                    end
                    6'h08, 6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: w_legal = 1'b1;
                    6'h0C: begin
                        w_legal        = 1'b1;
                        w_dec.exc      = 1'b1;
                        w_dec.exc_code = 5'd8;
                    end
                    6'h0D: begin
                        w_legal        = 1'b1;
                        w_dec.exc      = 1'b1;
                        w_dec.exc_code = 5'd9;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            6'h01: begin
                if ((w_rt == 5'h00) || (w_rt == 5'h01)) begin
                    w_legal  = 1'b1;
                    w_branch = 1'b1;
                end else if ((w_rt == 5'h10) || (w_rt == 5'h11)) begin
                    w_legal         = 1'b1;
                    w_branch        = 1'b1;
                    w_dec.reg_write = 1'b1;
                    w_dec.wsel      = 5'd31;
                end
            end
            6'h02: w_legal = 1'b1;
            6'h03: begin
                w_legal         = 1'b1;
                w_dec.reg_write = 1'b1;
                w_dec.wsel      = 5'd31;
            end
            6'h04, 6'h05, 6'h06, 6'h07: begin
                w_legal  = 1'b1;
                w_branch = 1'b1;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                w_legal         = 1'b1;
                w_dec.reg_write = 1'b1;
                w_dec.wsel      = w_rt;
            end
            6'h28, 6'h29, 6'h2B: w_legal = 1'b1;
            6'h10: begin
                if (bus.in_instr == 32'h4200_0018) begin
                    w_legal    = 1'b1;
                    w_dec.eret = 1'b1;
                end else if (w_rs == 5'h00) begin
                    w_legal         = 1'b1;
                    w_dec.reg_write = 1'b1;
                    w_dec.wsel      = w_rt;
                end else if (w_rs == 5'h04) begin
                    w_legal = 1'b1;
                end
            end
            default: w_legal = 1'b0;
        endcase

        if (w_legal) begin
            w_dec.alu_op    = {w_rfmt | w_ialu, w_branch};
            w_dec.alu_src   = w_ialu | w_load | w_store;
            w_dec.mem_read  = w_load;
            w_dec.mem_write = w_store;
            w_dec.mem_sign  = w_op[2];
            w_dec.mem_width = w_op[1:0];
        end else begin
            // Reserved encodings carry only the exception, never side effects.
            w_dec.reg_write = 1'b0;
            w_dec.wsel      = 5'd0;
            w_dec.eret      = 1'b0;
            w_dec.exc       = 1'b1;
            w_dec.exc_code  = 5'd10;
        end
    end

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_out_valid;
    logic             w_pop_raw;
    logic             w_push;
    logic             w_pop;
    logic             w_in_ready;
    logic             w_hazard;
    entry_t           w_head;

`ifdef DECODE_LOADUSE_INTERLOCK_EN
    logic                   r_rec_valid;
    logic [4:0]             r_rec_reg;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    logic                   w_reads_rs;
    logic                   w_reads_rt;

    assign w_reads_rs = !((w_op == 6'h02) || (w_op == 6'h03) || (w_op == 6'h0F) ||
                          (w_op == 6'h10) ||
                          (w_rfmt && ((w_funct == 6'h00) || (w_funct == 6'h02) ||
                                      (w_funct == 6'h03) || (w_funct == 6'h10) ||
                                      (w_funct == 6'h12) || (w_funct == 6'h0C) ||
                                      (w_funct == 6'h0D))));
    assign w_reads_rt = w_rfmt || (w_op == 6'h04) || (w_op == 6'h05) || w_store ||
                        ((w_op == 6'h10) && (w_rs == 5'h04));
    assign w_hazard   = r_rec_valid && bus.in_valid &&
                        ((w_reads_rs && (w_rs == r_rec_reg)) ||
                         (w_reads_rt && (w_rt == r_rec_reg)));

    // Load-use record: one-shot, consumed by the next accept or by the stall itself.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rec_valid <= 1'b0;
            r_rec_reg   <= 5'd0;
        end else if (flush || w_hazard) begin
            r_rec_valid <= 1'b0;
        end else if (w_push) begin
            r_rec_valid <= w_dec.mem_read && (w_rt != 5'd0);
            r_rec_reg   <= w_rt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_hazard && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign stall_count = r_stall_cnt;
`else
    assign w_hazard    = 1'b0;
    assign stall_count = '0;
`endif

    assign w_out_valid = (r_count != '0);
    assign w_pop_raw   = w_out_valid && bus.out_ready;
    assign w_in_ready  = ((r_count < CNT_W'(DEPTH)) || w_pop_raw) && !flush && !reset && !w_hazard;
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_pop_raw && !flush;

    // FIFO pointers and occupancy; flush discards everything including same-cycle traffic.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_dec;
        end
    end

    // Head entry is forced to zero whenever nothing valid is buffered.
    assign w_head = w_out_valid ? r_mem[r_rptr] : '0;

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = w_out_valid;
    assign bus.out_pc        = w_head.pc;
    assign bus.out_instr     = w_head.instr;
    assign bus.out_reg_write = w_head.reg_write;
    assign bus.out_wsel      = w_head.wsel;
    assign bus.out_alu_op    = w_head.alu_op;
    assign bus.out_alu_src   = w_head.alu_src;
    assign bus.out_mem_read  = w_head.mem_read;
    assign bus.out_mem_write = w_head.mem_write;
    assign bus.out_mem_sign  = w_head.mem_sign;
    assign bus.out_mem_width = w_head.mem_width;
    assign bus.out_exc       = w_head.exc;
    assign bus.out_exc_code  = w_head.exc_code;
    assign bus.out_eret      = w_head.eret;
endmodule

// File: tb/tb_decode_pipe.sv
// Scoreboard bench for decode_pipe: reference decode queued on accept, compared on pop.
module tb_decode_pipe;
    localparam int unsigned PC_WIDTH    = 32;
    localparam int unsigned STALL_CNT_W = 16;

    logic                   clock;
    logic                   reset;
    logic                   flush;
    logic [STALL_CNT_W-1:0] stall_count;

    decode_pipe_if #(.PC_WIDTH(PC_WIDTH)) bus ();

    decode_pipe #(
        .PC_WIDTH   (PC_WIDTH),
        .DEPTH      (4),
        .STALL_CNT_W(STALL_CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .bus        (bus),
        .stall_count(stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference decode, packed in output-port order.
    function automatic logic [84:0] ref_decode(input logic [31:0] pc, input logic [31:0] ins);
        logic [5:0] op;
        logic [4:0] rs, rt, rd;
        logic [5:0] fn;
        logic       legal, rw, br, rfmt, ialu, ld, st, exc, eret;
        logic [4:0] ws, code;
        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; fn = ins[5:0];
        legal = 0; rw = 0; br = 0; exc = 0; eret = 0; ws = 0; code = 0;
        rfmt = (op == 6'h00);
        ialu = (op >= 6'h08) && (op <= 6'h0F);
        ld   = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
        st   = op inside {6'h28, 6'h29, 6'h2B};
        if (rfmt) begin
            legal = fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                               6'h0C, 6'h0D, 6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19,
                               6'h1A, 6'h1B, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                               6'h26, 6'h27, 6'h2A, 6'h2B};
            rw = legal && !(fn inside {6'h08, 6'h0C, 6'h0D, 6'h11, 6'h13,
                                       6'h18, 6'h19, 6'h1A, 6'h1B});
            ws = rw ? rd : 5'd0;
            if (fn == 6'h0C) begin exc = 1; code = 8; end
            if (fn == 6'h0D) begin exc = 1; code = 9; end
        end else if (ialu || ld) begin
            legal = 1; rw = 1; ws = rt;
        end else if (st || op == 6'h02) begin
            legal = 1;
        end else if (op == 6'h03) begin
            legal = 1; rw = 1; ws = 31;
        end else if (op == 6'h01) begin
            legal = rt inside {5'h00, 5'h01, 5'h10, 5'h11};
            br = legal;
            if (legal && rt[4]) begin rw = 1; ws = 31; end
        end else if (op >= 6'h04 && op <= 6'h07) begin
            legal = 1; br = 1;
        end else if (op == 6'h10) begin
            if (ins == 32'h4200_0018) begin legal = 1; eret = 1; end
            else if (rs == 5'd0) begin legal = 1; rw = 1; ws = rt; end
            else if (rs == 5'd4) legal = 1;
        end
        if (!legal)
            return {pc, ins, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 5'd10, 1'b0};
        return {pc, ins, rw, ws, {rfmt | ialu, br}, ialu | ld | st, ld, st, op[2], op[1:0],
                exc, code, eret};
    endfunction

    logic [84:0] sb_q[$];

    // Scoreboard: compare on pop, enqueue on accept; reset/flush discard everything.
    always @(negedge clock) begin
        logic [84:0] got;
        if (reset || flush) begin
            sb_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                got = {bus.out_pc, bus.out_instr, bus.out_reg_write, bus.out_wsel, bus.out_alu_op,
                       bus.out_alu_src, bus.out_mem_read, bus.out_mem_write, bus.out_mem_sign,
                       bus.out_mem_width, bus.out_exc, bus.out_exc_code, bus.out_eret};
                if (sb_q.size() == 0) check("sb_unexpected_pop", 1, 0);
                else check("sb_head", 128'(got), 128'(sb_q.pop_front()));
            end
            if (bus.in_valid && bus.in_ready) sb_q.push_back(ref_decode(bus.in_pc, bus.in_instr));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        bus.in_valid = v;
        bus.in_pc    = pc;
        bus.in_instr = ins;
    endtask

    localparam logic [31:0] LW8      = 32'h8D28_0000;
    localparam logic [31:0] ADD_DEP  = 32'h010B_5020;
    localparam logic [31:0] ADD_FREE = 32'h012B_5020;

    logic [31:0] mix [5];
    logic [31:0] exv [4];
    logic [4:0]  exc_codes [4];

    initial begin
        mix[0] = 32'h012A_4020; mix[1] = 32'hAD09_0004; mix[2] = 32'h1109_FFFE;
        mix[3] = 32'h0C00_0040; mix[4] = 32'h0411_0003;
        exv[0] = 32'h0000_000C; exv[1] = 32'h0000_000D; exv[2] = 32'hFC00_0000;
        exv[3] = 32'h4200_0018;
        exc_codes[0] = 5'd8; exc_codes[1] = 5'd9; exc_codes[2] = 5'd10; exc_codes[3] = 5'd0;

        reset = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        set_in(1'b1, 32'h0, 32'h3C08_1234);
        repeat (2) step();
        check("rst_in_ready", 128'(bus.in_ready), 0);
        reset = 1'b0;
        set_in(1'b0, 32'h0, 32'h0);
        #1;
        check("rst_out_valid", 128'(bus.out_valid), 0);
        check("rst_stall", 128'(stall_count), 0);
        check("rst_out_pc", 128'(bus.out_pc), 0);
        check("rst_in_ready_after", 128'(bus.in_ready), 1);

        // lui $8 single transaction
        bus.out_ready = 1'b1;
        set_in(1'b1, 32'h100, 32'h3C08_1234);
        step();
        set_in(1'b0, 32'h0, 32'h0);
        check("lui_valid", 128'(bus.out_valid), 1);
        check("lui_reg_write", 128'(bus.out_reg_write), 1);
        check("lui_wsel", 128'(bus.out_wsel), 8);
        check("lui_alu_src", 128'(bus.out_alu_src), 1);
        check("lui_exc", 128'(bus.out_exc), 0);
        step();

        // Fill to full, then push-on-pop when full
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 32'h200 + 32'(4 * i), mix[i]);
            #1;
            check("fill_in_ready", 128'(bus.in_ready), 1);
            step();
        end
        set_in(1'b1, 32'h210, mix[4]);
        #1;
        check("full_in_ready", 128'(bus.in_ready), 0);
        check("full_head_pc", 128'(bus.out_pc), 32'h200);
        step();
        check("full_head_stable", 128'(bus.out_pc), 32'h200);
        bus.out_ready = 1'b1;
        #1;
        check("full_pop_in_ready", 128'(bus.in_ready), 1);
        step();
        bus.out_ready = 1'b0;
        set_in(1'b0, 32'h0, 32'h0);
        #1;
        check("after_pop_head_pc", 128'(bus.out_pc), 32'h204);
        bus.out_ready = 1'b1;
        repeat (4) step();
        check("drained_valid", 128'(bus.out_valid), 0);

        // syscall, break, reserved, eret
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 32'h300 + 32'(4 * i), exv[i]);
            step();
            check("exc_code", 128'(bus.out_exc_code), 128'(exc_codes[i]));
            check("exc_flag", 128'(bus.out_exc), (i < 3) ? 1 : 0);
            check("exc_eret", 128'(bus.out_eret), (i == 3) ? 1 : 0);
            check("exc_reg_write", 128'(bus.out_reg_write), 0);
        end
        set_in(1'b0, 32'h0, 32'h0);
        step();

        // Load-use interlock
        set_in(1'b1, 32'h400, LW8);
        step();
        set_in(1'b1, 32'h404, ADD_DEP);
        #1;
`ifdef DECODE_LOADUSE_INTERLOCK_EN
        check("lu_stall_ready", 128'(bus.in_ready), 0);
        step();
        check("lu_release_ready", 128'(bus.in_ready), 1);
        check("lu_stall_count", 128'(stall_count), 1);
        step();
`else
        check("lu_no_stall_ready", 128'(bus.in_ready), 1);
        step();
`endif
        set_in(1'b1, 32'h408, LW8);
        step();
        set_in(1'b1, 32'h40C, ADD_FREE);
        #1;
        check("lu_free_ready", 128'(bus.in_ready), 1);
        step();
        set_in(1'b0, 32'h0, 32'h0);
`ifdef DECODE_LOADUSE_INTERLOCK_EN
        check("lu_stall_total", 128'(stall_count), 1);
`else
        check("lu_stall_total", 128'(stall_count), 0);
`endif
        repeat (2) step();

        // Flush with an offer in the same cycle
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'h500 + 32'(4 * i), mix[i]);
            step();
        end
        set_in(1'b1, 32'h50C, 32'h4008_6000);
        flush = 1'b1;
        #1;
        check("flush_in_ready", 128'(bus.in_ready), 0);
        step();
        flush = 1'b0;
        set_in(1'b0, 32'h0, 32'h0);
        #1;
        check("flush_out_valid", 128'(bus.out_valid), 0);
        set_in(1'b1, 32'h600, 32'h3C08_1234);
        bus.out_ready = 1'b1;
        step();
        set_in(1'b0, 32'h0, 32'h0);
        check("post_flush_valid", 128'(bus.out_valid), 1);
        check("post_flush_pc", 128'(bus.out_pc), 32'h600);
        step();

        // Reset while full with a pending load record
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'h700 + 32'(4 * i), mix[i]);
            step();
        end
        set_in(1'b1, 32'h70C, LW8);
        step();
        set_in(1'b1, 32'h710, ADD_DEP);
        #1;
        check("full2_valid", 128'(bus.out_valid), 1);
        check("full2_in_ready", 128'(bus.in_ready), 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("rst2_out_valid", 128'(bus.out_valid), 0);
        check("rst2_stall", 128'(stall_count), 0);
        check("rst2_in_ready", 128'(bus.in_ready), 1);
        step();
        set_in(1'b0, 32'h0, 32'h0);
        bus.out_ready = 1'b1;
        repeat (3) step();
        check("sb_empty", 128'(sb_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
